// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU, DIV/DIVU/REM/REMU).
// Define EX_MULDIV_DIV_EN to build the restoring divider; without it divide ops return 0 after one cycle.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [2:0]      op_in,
    input  logic [XLEN-1:0] rs1_in,
    input  logic [XLEN-1:0] rs2_in,
    input  logic [4:0]      rd_in,
    output logic            busy_out,
    output logic            res_valid_out,
    output logic [XLEN-1:0] res_data_out,
    output logic [4:0]      res_rd_out
);
    localparam int ITER_W = $clog2(XLEN) + 1;
    localparam int MCNT_W = $clog2(MUL_CYCLES) + 1;
    localparam int CNT_W  = (ITER_W > MCNT_W) ? ITER_W : MCNT_W;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [4:0]        res_rd_q, res_rd_d;

    // MULH sign-extends both operands, MULHSU only rs1; the low 2*XLEN bits of the
    // sign-extended product equal the (XLEN+1)x(XLEN+1) signed product.
    logic              a_sign, b_sign;
    logic [2*XLEN-1:0] a_wide, b_wide;

    assign a_sign = ((op_in[1:0] == 2'd1) || (op_in[1:0] == 2'd2)) && rs1_in[XLEN-1];
    assign b_sign = (op_in[1:0] == 2'd1) && rs2_in[XLEN-1];
    assign a_wide = {{XLEN{a_sign}}, rs1_in};
    assign b_wide = {{XLEN{b_sign}}, rs2_in};

    function automatic logic [XLEN-1:0] mul_pick(input logic [1:0] op, input logic [2*XLEN-1:0] p);
        return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

`ifdef EX_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    // quo_q shifts the dividend magnitude out at the top while quotient bits enter at the bottom.
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rem_neg_q, rem_neg_d;

    logic            s1, s2;
    logic [XLEN:0]   shifted;
    logic            ge;
    logic [XLEN-1:0] sub;

    assign s1      = !op_in[0] && rs1_in[XLEN-1];
    assign s2      = !op_in[0] && rs2_in[XLEN-1];
    assign shifted = {rem_q, quo_q[XLEN-1]};
    assign ge      = shifted >= {1'b0, dvs_q};
    assign sub     = shifted[XLEN-1:0] - dvs_q;
`endif

    assign req_ready_out = (state_q == S_IDLE) && !flush_in;
    assign busy_out      = (state_q != S_IDLE);
    assign res_valid_out = (state_q == S_DONE) && rdy_in && !flush_in;
    assign res_data_out  = res_q;
    assign res_rd_out    = res_rd_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        prod_d   = prod_q;
        res_d    = res_q;
        res_rd_d = res_rd_q;
`ifdef EX_MULDIV_DIV_EN
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (req_valid_in && req_ready_out) begin
                    op_d = op_in[1:0];
                    rd_d = rd_in;
                    if (!op_in[2]) begin
                        prod_d = a_wide * b_wide;
                        cnt_d  = MUL_LOAD;
                        if (MUL_CYCLES == 1) begin
                            state_d  = S_DONE;
                            res_d    = mul_pick(op_in[1:0], a_wide * b_wide);
                            res_rd_d = rd_in;
                        end else begin
                            state_d = S_MUL;
                        end
                    end else begin
`ifdef EX_MULDIV_DIV_EN
                        if (rs2_in == '0) begin
                            state_d  = S_DONE;
                            res_d    = op_in[1] ? rs1_in : '1;
                            res_rd_d = rd_in;
                        end else if (!op_in[0] && (rs1_in == INT_MIN) && (rs2_in == '1)) begin
                            state_d  = S_DONE;
                            res_d    = op_in[1] ? '0 : rs1_in;
                            res_rd_d = rd_in;
                        end else begin
                            state_d   = S_DIV;
                            cnt_d     = CNT_W'(XLEN - 1);
                            quo_d     = s1 ? -rs1_in : rs1_in;
                            rem_d     = '0;
                            dvs_d     = s2 ? -rs2_in : rs2_in;
                            quo_neg_d = s1 ^ s2;
                            rem_neg_d = s1;
                        end
`else
                        state_d  = S_DONE;
                        res_d    = '0;
                        res_rd_d = rd_in;
`endif
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_ONE) begin
                    state_d  = S_DONE;
                    cnt_d    = '0;
                    res_d    = mul_pick(op_q, prod_q);
                    res_rd_d = rd_q;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DIV: begin
`ifdef EX_MULDIV_DIV_EN
                quo_d = {quo_q[XLEN-2:0], ge};
                rem_d = ge ? sub : shifted[XLEN-1:0];
                if (cnt_q == '0) begin
                    state_d  = S_DONE;
                    res_rd_d = rd_q;
                    if (op_q[1]) res_d = rem_neg_q ? -rem_d : rem_d;
                    else         res_d = quo_neg_q ? -quo_d : quo_d;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons the operation without touching the visible result registers.
        if (flush_in) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            res_d    = res_q;
            res_rd_d = res_rd_q;
        end
    end

    // NOTE: every register updates only when rdy_in is high, with non-blocking
    // assignments, so a stalled pipeline freezes state, counter and datapath together.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            prod_q   <= '0;
            res_q    <= '0;
            res_rd_q <= '0;
`ifdef EX_MULDIV_DIV_EN
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            prod_q   <= prod_d;
            res_q    <= res_d;
            res_rd_q <= res_rd_d;
`ifdef EX_MULDIV_DIV_EN
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
`endif
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: vector table plus flush, stall and reset sequences.
// Expected divide results follow EX_MULDIV_DIV_EN (zero after one cycle when undefined).
module tb_ex_muldiv;
    localparam int XLEN = 32;
`ifdef EX_MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic            clk_in       = 1'b0;
    logic            rst_in       = 1'b1;
    logic            rdy_in       = 1'b1;
    logic            flush_in     = 1'b0;
    logic            req_valid_in = 1'b0;
    logic            req_ready_out;
    logic [2:0]      op_in        = '0;
    logic [XLEN-1:0] rs1_in       = '0;
    logic [XLEN-1:0] rs2_in       = '0;
    logic [4:0]      rd_in        = '0;
    logic            busy_out;
    logic            res_valid_out;
    logic [XLEN-1:0] res_data_out;
    logic [4:0]      res_rd_out;

    ex_muldiv #(.XLEN(XLEN), .MUL_CYCLES(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush_in     (flush_in),
        .req_valid_in (req_valid_in),
        .req_ready_out(req_ready_out),
        .op_in        (op_in),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .rd_in        (rd_in),
        .busy_out     (busy_out),
        .res_valid_out(res_valid_out),
        .res_data_out (res_data_out),
        .res_rd_out   (res_rd_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] last_data = '0;
    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk_in) begin
        if (res_valid_out === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", res_valid_out, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check("res_data", res_data_out, mon_e.data);
                check("res_rd", res_rd_out, mon_e.rd);
                check("latency", cyc + 1, mon_e.due);
                last_data = mon_e.data;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit push);
        int n = 0;
        @(negedge clk_in);
        while (req_ready_out !== 1'b1 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        check("req_ready", req_ready_out, 1'b1);
        op_in        = op;
        rs1_in       = a;
        rs2_in       = b;
        rd_in        = rd;
        req_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        req_valid_in = 1'b0;
        if (push) sb.push_back('{exp, rd, cyc + lat});
        check("busy_after_accept", busy_out, 1'b1);
    endtask

    task automatic drain();
        int n       = 0;
        bit dropped = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk_in);
            #1;
            if (sb.size() != 0 && busy_out !== 1'b1) dropped = 1'b1;
            n++;
        end
        check("drain_timeout", sb.size(), 0);
        check("busy_throughout", dropped, 1'b0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        vec_t vecs[22];
        vecs[0]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2};
        vecs[1]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2};
        vecs[3]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
        vecs[4]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 2};
        vecs[5]  = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 2};
        vecs[6]  = '{3'd3, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 2};
        vecs[7]  = '{3'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 2};
        vecs[8]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[9]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[10] = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[11] = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd7, 32'd5,         32'd0,         32'd5,         1};
        vecs[14] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[15] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[16] = '{3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[17] = '{3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33};
        vecs[18] = '{3'd4, 32'h8000_0000, 32'd1,         32'h8000_0000, 33};
        vecs[19] = '{3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        vecs[20] = '{3'd5, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 33};
        vecs[21] = '{3'd7, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 33};

        // Reset state.
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check("rst_busy", busy_out, 1'b0);
        check("rst_valid", res_valid_out, 1'b0);
        check("rst_data", res_data_out, 32'h0);
        check("rst_rd", res_rd_out, 5'h0);
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ready_after_rst", req_ready_out, 1'b1);
        flush_in = 1'b1;
        #1;
        check("ready_under_flush", req_ready_out, 1'b0);
        flush_in = 1'b0;

        // Table-driven operations.
        for (int i = 0; i < 22; i++) begin
            logic [31:0] e_data;
            int          e_lat;
            e_data = (vecs[i].op[2] && !DIV_EN) ? 32'h0 : vecs[i].exp;
            e_lat  = (vecs[i].op[2] && !DIV_EN) ? 1 : vecs[i].lat;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), e_data, e_lat, 1'b1);
            drain();
        end
        @(negedge clk_in);
        check("hold_valid", res_valid_out, 1'b0);
        check("hold_data", res_data_out, last_data);

        // Flush in the 10th divide cycle (in the first multiply cycle without a divider).
        issue(DIV_EN ? 3'd5 : 3'd3, 32'd100, 32'd7, 5'd9, 32'h0, 0, 1'b0);
        repeat (DIV_EN ? 9 : 0) @(posedge clk_in);
        @(negedge clk_in);
        flush_in = 1'b1;
        @(posedge clk_in);
        #1;
        flush_in = 1'b0;
        @(negedge clk_in);
        check("flush_ready", req_ready_out, 1'b1);
        check("flush_busy", busy_out, 1'b0);
        check("flush_hold_data", res_data_out, last_data);
        repeat (40) @(negedge clk_in);

        // rdy_in low for five cycles mid-operation stretches latency by five.
        issue(DIV_EN ? 3'd4 : 3'd0, DIV_EN ? 32'hFFFF_FFF9 : 32'd7, DIV_EN ? 32'd2 : 32'hFFFF_FFFD,
              5'd11, DIV_EN ? 32'hFFFF_FFFD : 32'hFFFF_FFEB, DIV_EN ? 38 : 7, 1'b1);
        repeat (DIV_EN ? 3 : 0) @(posedge clk_in);
        @(negedge clk_in);
        rdy_in = 1'b0;
        repeat (5) @(negedge clk_in);
        rdy_in = 1'b1;
        drain();

        // Asynchronous reset in the middle of a multiply.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd13, 32'h0, 0, 1'b0);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_busy", busy_out, 1'b0);
        check("arst_valid", res_valid_out, 1'b0);
        check("arst_data", res_data_out, 32'h0);
        check("arst_rd", res_rd_out, 5'h0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        check("ready_after_arst", req_ready_out, 1'b1);
        repeat (5) @(negedge clk_in);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
